// File: rtl/dm_pkg.sv
// Shared constants and state encoding for the dot-matrix scanner.
package dm_pkg;

    localparam int ROWS    = 8;
    localparam int FRAMES  = 8;
    localparam int ROW_W   = 3;
    localparam int FRAME_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        BLANK = ST_BLANK,
        SHOW  = ST_SHOW
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dm_mod_counter.sv
// Modulo-MOD up counter with synchronous clear (clear wins over increment).
// wrap flags the terminal count MOD-1.
module dm_mod_counter #(
    parameter  int MOD = 8,
    localparam int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = (cnt == W'(MOD - 1));

    // Count register: clear, else step and roll over at MOD-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= wrap ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/dot_matrix_scan.sv
// 8x8 LED matrix scanner: ROM addressing, row/blank sequencing and
// frame advance (auto after FRAME_HOLD scans, or manual select).
module dot_matrix_scan
    import dm_pkg::*;
#(
    parameter int SCAN_DIV   = 4000,
    parameter int BLANK_CYC  = 8,
    parameter int FRAME_HOLD = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               manual,
    input  logic [FRAME_W-1:0] frame_in,
    output logic [5:0]         rom_addr,
    input  logic [7:0]         rom_data,
    output logic [ROWS-1:0]    row_n,
    output logic [7:0]         col,
    output logic [FRAME_W-1:0] frame_cur,
    output logic               frame_tick
);

    localparam int DIV_MOD = max2(SCAN_DIV, BLANK_CYC);
    localparam int DIV_W   = $clog2(DIV_MOD);
    localparam int SCAN_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    state_t r_state, w_state_nxt;

    logic [DIV_W-1:0]   w_div_cnt;
    logic               w_div_wrap, w_div_clr, w_div_inc;
    logic [ROW_W-1:0]   w_row;
    logic               w_row_wrap, w_row_clr, w_row_inc;
    logic [SCAN_W-1:0]  w_scan_cnt;
    logic               w_scan_wrap, w_scan_clr, w_scan_inc;

    logic               w_blank_last, w_show_last, w_boundary;
    logic [FRAME_W-1:0] w_frame_nxt;
    logic [ROW_W-1:0]   w_row_nxt;

    logic [ROWS-1:0]    r_row_n;
    logic [7:0]         r_col;
    logic [5:0]         r_rom_addr;
    logic [FRAME_W-1:0] r_frame_cur;
    logic               r_frame_tick;

    // Only the terminal flags / counts below are needed from these.
    logic w_unused;
    assign w_unused = &{1'b0, w_div_wrap, w_scan_cnt};

    // Shared timer: counts clocks within the current BLANK or SHOW phase.
    dm_mod_counter #(.MOD(DIV_MOD)) u_div (
        .clk(clk), .rst_n(rst_n), .clr(w_div_clr), .inc(w_div_inc),
        .cnt(w_div_cnt), .wrap(w_div_wrap)
    );

    dm_mod_counter #(.MOD(ROWS)) u_row (
        .clk(clk), .rst_n(rst_n), .clr(w_row_clr), .inc(w_row_inc),
        .cnt(w_row), .wrap(w_row_wrap)
    );

    dm_mod_counter #(.MOD(FRAME_HOLD)) u_scan (
        .clk(clk), .rst_n(rst_n), .clr(w_scan_clr), .inc(w_scan_inc),
        .cnt(w_scan_cnt), .wrap(w_scan_wrap)
    );

    assign w_blank_last = (r_state == BLANK) && (w_div_cnt == DIV_W'(BLANK_CYC - 1));
    assign w_show_last  = (r_state == SHOW)  && (w_div_cnt == DIV_W'(SCAN_DIV - 1));
    assign w_boundary   = w_show_last && w_row_wrap;
    assign w_row_nxt    = w_row + 1'b1;

    // Frame to show after the current row; it only moves at the 7->0 row wrap.
    always_comb begin
        w_frame_nxt = r_frame_cur;
        if (w_boundary) begin
            if (manual)           w_frame_nxt = frame_in;
            else if (w_scan_wrap) w_frame_nxt = r_frame_cur + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and counter controls; disable overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_div_clr   = 1'b0;
        w_div_inc   = 1'b0;
        w_row_clr   = 1'b0;
        w_row_inc   = 1'b0;
        w_scan_clr  = manual;
        w_scan_inc  = w_boundary;
        if (!en) begin
            w_state_nxt = IDLE;
            w_div_clr   = 1'b1;
            w_row_clr   = 1'b1;
            w_scan_clr  = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = BLANK;
                    w_div_clr   = 1'b1;
                end
                BLANK: begin
                    w_div_inc = 1'b1;
                    if (w_blank_last) begin
                        w_state_nxt = SHOW;
                        w_div_clr   = 1'b1;
                    end
                end
                SHOW: begin
                    w_div_inc = 1'b1;
                    if (w_show_last) begin
                        w_state_nxt = BLANK;
                        w_div_clr   = 1'b1;
                        w_row_inc   = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Output registers: row/col change only at phase edges, so a row is
    // never lit with another row's column data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_n      <= '1;
            r_col        <= '0;
            r_rom_addr   <= '0;
            r_frame_cur  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            if (!en) begin
                r_row_n    <= '1;
                r_col      <= '0;
                r_rom_addr <= {r_frame_cur, 3'd0};
            end else begin
                case (r_state)
                    BLANK: begin
                        if (w_blank_last) begin
                            r_row_n <= ~(8'b1 << w_row);
                            r_col   <= rom_data;
                        end
                    end
                    SHOW: begin
                        if (w_show_last) begin
                            r_row_n      <= '1;
                            r_col        <= '0;
                            r_rom_addr   <= {w_frame_nxt, w_row_nxt};
                            r_frame_cur  <= w_frame_nxt;
                            r_frame_tick <= (w_frame_nxt != r_frame_cur);
                        end
                    end
                    default: begin
                        r_row_n <= '1;
                        r_col   <= '0;
                    end
                endcase
            end
        end
    end

    assign row_n      = r_row_n;
    assign col        = r_col;
    assign rom_addr   = r_rom_addr;
    assign frame_cur  = r_frame_cur;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_dot_matrix_scan.sv
// Scoreboard bench for dot_matrix_scan: expected lit rows are queued as the
// stimulus is decided and checked each time a row lights up.
module tb_dot_matrix_scan;

    localparam int SCAN_DIV   = 4;
    localparam int BLANK_CYC  = 1;
    localparam int FRAME_HOLD = 2;

    logic       clk = 1'b0;
    logic       rst_n, en, manual;
    logic [2:0] frame_in;
    logic [5:0] rom_addr;
    logic [7:0] rom_data, row_n, col;
    logic [2:0] frame_cur;
    logic       frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_cnt;
    int t0;

    logic [5:0] q[$];
    int m_frame, m_row, m_scan;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [5:0] a);
        case (a)
            6'd0:  rom_f = 8'h3C; 6'd1:  rom_f = 8'h42; 6'd2:  rom_f = 8'hA5; 6'd3:  rom_f = 8'h81;
            6'd4:  rom_f = 8'h81; 6'd5:  rom_f = 8'hA5; 6'd6:  rom_f = 8'h42; 6'd7:  rom_f = 8'h3C;
            6'd8:  rom_f = 8'h01; 6'd9:  rom_f = 8'h03; 6'd10: rom_f = 8'h0C; 6'd11: rom_f = 8'h18;
            6'd12: rom_f = 8'h30; 6'd13: rom_f = 8'h60; 6'd14: rom_f = 8'hC0; 6'd15: rom_f = 8'h80;
            6'd24: rom_f = 8'h04;
            default: rom_f = {a, 2'b10};
        endcase
    endfunction

    assign rom_data = rom_f(rom_addr);

    dot_matrix_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .FRAME_HOLD(FRAME_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .manual(manual), .frame_in(frame_in),
        .rom_addr(rom_addr), .rom_data(rom_data), .row_n(row_n), .col(col),
        .frame_cur(frame_cur), .frame_tick(frame_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Queue the next n rows the display should light, stepping a spec-level
    // model of row/scan/frame progression using the current mode inputs.
    task automatic push_rows(input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back({m_frame[2:0], m_row[2:0]});
            if (m_row == 7) begin
                if (manual) begin
                    m_frame = int'(frame_in);
                    m_scan  = 0;
                end else if (m_scan == FRAME_HOLD - 1) begin
                    m_scan  = 0;
                    m_frame = (m_frame + 1) % 8;
                end else begin
                    m_scan++;
                end
            end
            m_row = (m_row + 1) % 8;
        end
    endtask

    task automatic wait_drain(input int limit);
        int k = 0;
        while (q.size() != 0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    // Monitor: per-clock invariants plus scoreboard pop on each lit row.
    logic [7:0] prev_row_n;
    logic [2:0] prev_frame;
    logic [7:0] exp_rn;
    logic [5:0] a;
    int  gap, cur_len, last_len;
    bit  have_prev, en_low;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_row_n = 8'hFF; prev_frame = 3'd0; have_prev = 0; en_low = 0;
            gap = 0; cur_len = 0; last_len = 0; tick_cnt = 0;
        end else begin
            chk("onehot", 32'(row_n == 8'hFF || $onehot(~row_n)), 1);
            if (row_n == 8'hFF) chk("blank_col", col, 0);
            if (!en) en_low = 1;
            if (frame_tick) begin
                tick_cnt++;
                chk("tick_chg", 32'(frame_cur != prev_frame), 1);
            end
            if (row_n != 8'hFF) begin
                if (prev_row_n == 8'hFF) begin
                    if (have_prev && !en_low) begin
                        chk("gap", gap, BLANK_CYC);
                        chk("show_len", last_len, SCAN_DIV);
                    end
                    if (q.size() == 0) begin
                        chk("unexp_row", 1, 0);
                    end else begin
                        a = q.pop_front();
                        exp_rn = ~(8'b1 << a[2:0]);
                        chk("row_n", row_n, exp_rn);
                        chk("col", col, rom_f(a));
                        chk("addr", rom_addr, a);
                        chk("frame", frame_cur, a[5:3]);
                    end
                    have_prev = 1; en_low = 0; gap = 0; cur_len = 0;
                end
                cur_len++;
            end else begin
                if (prev_row_n != 8'hFF) last_len = cur_len;
                gap++;
            end
            prev_row_n = row_n;
            prev_frame = frame_cur;
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; manual = 1'b0; frame_in = 3'd0;
        m_frame = 0; m_row = 0; m_scan = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_row_n", row_n, 8'hFF);
        chk("rst_col", col, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_tick", frame_tick, 0);

        // Reset asserted in the middle of a SHOW phase.
        rst_n = 1'b1; en = 1'b1;
        push_rows(1);
        wait_drain(20);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_row_n", row_n, 8'hFF);
        chk("midrst_col", col, 0);
        chk("midrst_addr", rom_addr, 0);
        chk("midrst_frame", frame_cur, 0);
        en = 1'b0;
        q.delete();
        m_frame = 0; m_row = 0; m_scan = 0;
        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b1;

        // Auto scan: one IDLE clock, one BLANK clock, then row 0 lit.
        push_rows(130);
        chk("idle_row_n", row_n, 8'hFF);
        @(posedge clk); #1;
        chk("blank_row_n", row_n, 8'hFF);
        chk("blank_addr", rom_addr, 0);
        @(posedge clk); #1;
        chk("row0_row_n", row_n, 8'hFE);
        chk("row0_col", col, 8'h3C);
        // Frames 0..7 twice each, wrap back to frame 0 rows 0-1.
        wait_drain(130 * 5 + 40);
        chk("wrap_ticks", tick_cnt, 8);
        chk("wrap_frame", frame_cur, 0);

        // Manual select taken mid-frame; frame 0 finishes first.
        manual = 1'b1; frame_in = 3'd3;
        t0 = tick_cnt;
        push_rows(6 + 16);
        wait_drain(22 * 5 + 40);
        chk("man_ticks", tick_cnt - t0, 1);
        chk("man_frame", frame_cur, 3);

        // Disable mid-SHOW of row 4, then re-enable from row 0.
        push_rows(5);
        wait_drain(5 * 5 + 40);
        en = 1'b0;
        @(posedge clk); #1;
        chk("dis_row_n", row_n, 8'hFF);
        chk("dis_col", col, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("dis_addr", rom_addr, 6'd24);
        chk("dis_frame", frame_cur, 3);
        q.delete();
        m_row = 0; m_scan = 0;
        t0 = tick_cnt;
        en = 1'b1;
        push_rows(8);
        wait_drain(8 * 5 + 40);
        chk("reen_ticks", tick_cnt - t0, 0);
        chk("reen_frame", frame_cur, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
